// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//
// Bridges the L2 memory-side port to a narrower physical memory bus. A full-line
// fill or writeback from the L2 is split into BEATS ascending beats (beat 0 holds
// the lowest address and the line LSBs). Read beats are reassembled into one line
// and returned with a single-cycle line_resp. One transaction is in flight at a time.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   line_addr     : L2 request byte address
//   line_read     : L2 fill request, held until line_resp
//   line_write    : L2 writeback request, held until line_resp
//   line_wdata    : writeback line
//   line_rdata    : assembled fill line (registered)
//   line_resp     : one-cycle completion pulse (registered)
//   burst_addr    : line-aligned burst address (registered)
//   burst_read    : burst read request, held for the whole burst (registered)
//   burst_write   : burst write request, held for the whole burst (registered)
//   burst_wdata   : current write beat (registered)
//   burst_rdata   : current read beat
//   burst_resp    : beat accepted (write) / beat valid (read)

module l2_cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] line_addr,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Byte-offset bits within a line; cleared to form the burst address.
    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_WIDTH-1:0] wdata_q, wdata_d;
    logic                  burst_read_q, burst_read_d;
    logic                  burst_write_q, burst_write_d;
    logic                  line_resp_q, line_resp_d;

    // Offset bits never reach the memory bus.
    logic unused_addr_offset;
    assign unused_addr_offset = ^line_addr[OFF_W-1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wbuf_d        = wbuf_q;
        rdata_d       = rdata_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        burst_read_d  = burst_read_q;
        burst_write_d = burst_write_q;
        line_resp_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Read has priority if the L2 illegally raises both requests.
                if (line_read) begin
                    addr_d       = {line_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d        = '0;
                    burst_read_d = 1'b1;
                    state_d      = StRead;
                end else if (line_write) begin
                    addr_d        = {line_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    wbuf_d        = line_wdata;
                    wdata_d       = line_wdata[BEAT_WIDTH-1:0];
                    cnt_d         = '0;
                    burst_write_d = 1'b1;
                    state_d       = StWrite;
                end
            end
            StRead: begin
                if (burst_resp) begin
                    rdata_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        burst_read_d = 1'b0;
                        line_resp_d  = 1'b1;
                        state_d      = StDone;
                    end
                end
            end
            StWrite: begin
                if (burst_resp) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Present the next beat in the cycle after the accept.
                    wdata_d = wbuf_q[cnt_d*BEAT_WIDTH +: BEAT_WIDTH];
                    if (cnt_q == LAST_BEAT) begin
                        burst_write_d = 1'b0;
                        line_resp_d   = 1'b1;
                        state_d       = StDone;
                    end
                end
            end
            StDone: begin
                // Requests are ignored here; the L2 drops them after seeing line_resp.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wbuf_q        <= '0;
            rdata_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            line_resp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wbuf_q        <= wbuf_d;
            rdata_q       <= rdata_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            burst_read_q  <= burst_read_d;
            burst_write_q <= burst_write_d;
            line_resp_q   <= line_resp_d;
        end
    end

    assign line_rdata  = rdata_q;
    assign line_resp   = line_resp_q;
    assign burst_addr  = addr_q;
    assign burst_read  = burst_read_q;
    assign burst_write = burst_write_q;
    assign burst_wdata = wdata_q;

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache, between its memory-side port and the physical memory.
- Converts each full-line L2 transaction (256-bit read or writeback) into a burst of 64-bit beats on the physical memory bus.
- On reads, it assembles the beats back into one line and returns it with a single-cycle response.
- Serves one outstanding transaction at a time; the L2 holds its request until it sees the response.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; must equal BEAT_WIDTH*BEATS.
- BEAT_WIDTH, 64, physical memory data bus width.
- ADDR_WIDTH, 32, byte address width.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), derived local value: beats per line.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- line_addr  in  ADDR_WIDTH  L2 request byte address.
- line_read  in  1  L2 line fill request, held until line_resp.
- line_write  in  1  L2 writeback request, held until line_resp.
- line_wdata  in  LINE_WIDTH  writeback line.
- line_rdata  out  LINE_WIDTH  assembled fill line.
- line_resp  out  1  one-cycle completion pulse.
- burst_addr  out  ADDR_WIDTH  line-aligned burst address.
- burst_read  out  1  burst read request, held for the whole burst.
- burst_write  out  1  burst write request, held for the whole burst.
- burst_wdata  out  BEAT_WIDTH  current write beat.
- burst_rdata  in  BEAT_WIDTH  current read beat.
- burst_resp  in  1  beat accepted (write) or beat valid (read), one per cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state goes to IDLE, beat counter to 0. All outputs are registered and reset to 0: burst_read, burst_write, line_resp, burst_addr, burst_wdata, line_rdata.
- Reset mid-burst aborts the transaction with no line_resp; memory-side recovery is the system's responsibility.
- States: IDLE, READ, WRITE, DONE.
- IDLE, line_read=1:
  - Latch burst_addr = {line_addr[ADDR_WIDTH-1:5], 5'b0}.
  - Clear the counter; go to READ; burst_read=1 from the next cycle.
- IDLE, line_write=1 (and line_read=0):
  - Latch the address (aligned the same way) and line_wdata into the write buffer.
  - burst_wdata = beat 0 (bits 63:0); go to WRITE; burst_write=1 from the next cycle.
- Read and write both high in IDLE is illegal. Read wins and the write is ignored; the bench flags it as an assertion.
- READ:
  - Each cycle with burst_resp=1: store burst_rdata into line_rdata[cnt*64 +: 64], then cnt++.
  - Beat order is ascending: beat 0 is the lowest address and the LSBs.
  - Cycles with burst_resp=0 are wait states; nothing changes.
  - On the resp that captures beat BEATS-1: deassert burst_read next cycle, go to DONE.
- WRITE:
  - burst_wdata always shows the beat at index cnt.
  - Each burst_resp=1 advances cnt, and burst_wdata updates to the next beat in the following cycle.
  - On the resp for beat BEATS-1: deassert burst_write, go to DONE.
- DONE:
  - line_resp=1 for exactly one cycle, then back to IDLE.
  - line_rdata holds the assembled line from the DONE cycle until the next read starts capturing. It is unchanged by writes.
- Request handling after a transaction: DONE ignores requests. The L2 drops its request in the cycle after seeing line_resp, so a new request is sampled in IDLE no earlier than one cycle after DONE.
- burst_resp in IDLE or DONE is ignored.
- The counter is log2(BEATS) bits wide and wraps to 0 after the last beat.
- line_addr and line_wdata changes after capture have no effect until the next IDLE acceptance.
- Latency: request in IDLE at cycle 0, burst request asserted at cycle 1. With burst_resp continuously high from cycle 1, beats land in cycles 1-4, DONE/line_resp is at cycle 5, and IDLE is at cycle 6.

Test Plan:
- Reset: assert rst_n=0 mid-READ after 2 beats -> all outputs 0 immediately; the following read restarts at beat 0 and gives a correct line.
- Back-to-back read, no waits: line_read, addr 0x0000_1234; beats 0x...AAAA0, ..1, ..2, ..3 with burst_resp every cycle from cycle 1 -> burst_addr=0x0000_1220, burst_read high cycles 1-4, line_resp only at cycle 5, line_rdata = {beat3,beat2,beat1,beat0}.
- Read with waits: burst_resp pattern 1,0,0,1,1,0,1 -> beats captured only on resp cycles; line_resp exactly one cycle after the 4th resp; burst_read stays high throughout.
- Writeback: line_write, addr 0xFFFF_FFE7, wdata = 0x4444..._3333..._2222..._1111... -> burst_addr=0xFFFF_FFE0; burst_wdata goes 0x1111.., 0x2222.., 0x3333.., 0x4444.., each advancing only after its resp; single line_resp; line_rdata unchanged from the previous read.
- Write then read: the L2 holds line_read immediately after dropping line_write -> the read is accepted one cycle after DONE; no beat overlap, no double line_resp.
- Illegal/stray inputs: burst_resp pulsed in IDLE -> no state change, no line_resp; line_read and line_write both high -> read burst issued, burst_write stays 0.
